// File: rtl/tx_pkg.sv
// -----------------------------------------------------------------------------
// tx_pkg
// Shared definitions for the UART transmit arbiter.
//   state_t    : FSM state encodings (IDLE, LOAD, SEND, GAP)
//   FRAME_BITS : serial bit-times per frame (start + 8 data + stop)
// No ports.
// -----------------------------------------------------------------------------
package tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// tx_arbiter_if
// Bundle of requester-side and transmitter-side signals of the arbiter.
//   req      : per-requester transmit request (level)
//   req_data : per-requester byte, slice i = [8i+7:8i]
//   ack      : one-hot acceptance pulse
//   done     : frame-plus-gap completion pulse
//   busy     : arbiter not idle
//   tx_data  : byte presented to the transmitter
//   load     : frame start pulse to the transmitter
//   txen     : bit-rate strobe to the transmitter
// Modports: master = requester/transmitter side, slave = arbiter.
// -----------------------------------------------------------------------------
interface tx_arbiter_if #(
  parameter int NREQ = 4
) ();

  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic              done;
  logic              busy;
  logic [7:0]        tx_data;
  logic              load;
  logic              txen;

  modport master (
    output req, req_data,
    input  ack, done, busy, tx_data, load, txen
  );

  modport slave (
    input  req, req_data,
    output ack, done, busy, tx_data, load, txen
  );

endinterface

// File: rtl/tx_arbiter_baud_gen.sv
// -----------------------------------------------------------------------------
// baud_gen
// Bit-rate strobe generator. The counter runs 0..BAUD_DIV-1 while enabled and
// txen is high for the one cycle in which the counter holds BAUD_DIV-1.
// Ports:
//   clk    : clock
//   rst    : synchronous active-high reset
//   clear  : force counter and strobe to zero
//   enable : advance the counter
//   txen   : registered bit-rate strobe
// -----------------------------------------------------------------------------
module baud_gen #(
  parameter int BAUD_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic txen
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
  // txen is a flop, so it is set one count early to line up with CNT_LAST.
  localparam logic [CW-1:0] CNT_PRE  = CW'(BAUD_DIV - 2);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      txen <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      txen <= 1'b0;
    end else if (enable) begin
      cnt  <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      txen <= (cnt == CNT_PRE);
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// -----------------------------------------------------------------------------
// tx_arbiter
// Round-robin arbiter sharing one UART transmitter among NREQ requesters.
// A grant in IDLE latches the winner's byte, LOAD pulses load/ack for one
// cycle, SEND counts FRAME_BITS bit strobes, GAP counts GAP_BITS idle bit
// strobes, then done pulses on the first cycle back in IDLE.
// Ports:
//   clk : clock
//   rst : synchronous active-high reset, aborts any frame without done
//   bus : tx_arbiter_if.slave (req, req_data in; ack, done, busy, tx_data,
//         load, txen out; all outputs registered)
// -----------------------------------------------------------------------------
module tx_arbiter
  import tx_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int BAUD_DIV = 16,
  parameter int GAP_BITS = 1
) (
  input logic           clk,
  input logic           rst,
  tx_arbiter_if.slave   bus
);

  localparam int IDXW = $clog2(NREQ);
  localparam int GW   = $clog2(GAP_BITS + 1);
  localparam logic [3:0]    BIT_LAST = 4'(FRAME_BITS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_BITS - 1);

  state_t          state;
  logic [IDXW-1:0] last_gnt;
  logic [IDXW-1:0] sel;
  logic [IDXW-1:0] gnt;
  logic [3:0]      bit_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            baud_clear;
  logic            baud_en;

  // Search from the farthest candidate back to last+1 so the nearest
  // requester above the last grant (with wrap) is the one left in res.
  function automatic logic [IDXW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IDXW-1:0] last);
    logic [IDXW-1:0] res;
    int idx;
    res = last;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if (r[idx]) res = IDXW'(idx);
    end
    return res;
  endfunction

  assign gnt = rr_pick(bus.req, last_gnt);

  // The baud counter restarts from zero whenever a frame is not on the wire.
  assign baud_clear = (state == IDLE) || (state == LOAD);
  assign baud_en    = (state == SEND) || (state == GAP);

  baud_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_gen (
    .clk    (clk),
    .rst    (rst),
    .clear  (baud_clear),
    .enable (baud_en),
    .txen   (bus.txen)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_gnt    <= IDXW'(NREQ - 1);
      sel         <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      bus.tx_data <= '0;
      bus.load    <= 1'b0;
      bus.ack     <= '0;
      bus.done    <= 1'b0;
      bus.busy    <= 1'b0;
    end else begin
      bus.load <= 1'b0;
      bus.ack  <= '0;
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            sel         <= gnt;
            bus.tx_data <= bus.req_data[8*int'(gnt) +: 8];
            bus.load    <= 1'b1;
            bus.ack     <= NREQ'(1) << gnt;
            bus.busy    <= 1'b1;
            state       <= LOAD;
          end
        end
        LOAD: begin
          last_gnt <= sel;
          bit_cnt  <= '0;
          state    <= SEND;
        end
        SEND: begin
          if (bus.txen) begin
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              gap_cnt <= '0;
              state   <= GAP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        GAP: begin
          if (bus.txen) begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt  <= '0;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              state    <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
